// File: rtl/divider_32b.sv
// divider_32b
// -----------
// Multi-cycle 32-bit integer divider for the RV32M datapath (DIV, DIVU,
// REM, REMU). It uses radix-2 restoring division with a fixed latency:
// the accept edge, 32 iteration edges (CALC), then one correction edge (FIX).
// Special cases (divide by zero, signed overflow) still take the full time.
//
// Ports
//   CLK     : rising-edge clock
//   RST     : asynchronous, active-high reset
//   Start   : request a new operation; sampled only while Busy is low
//   Op      : 00=DIV, 01=DIVU, 10=REM, 11=REMU
//   A, B    : dividend and divisor, sampled at the accepting edge only
//   F       : quotient (Op[1]=0) or remainder (Op[1]=1); held until next FIX
//   Busy    : operation in progress
//   Done    : one-cycle pulse marking F valid
//   DivZero : divisor was zero for the last completed operation

module divider_32b #(
   parameter int DATA_LENGTH = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   Start,
   input  logic [1:0]             Op,
   input  logic [DATA_LENGTH-1:0] A,
   input  logic [DATA_LENGTH-1:0] B,
   output logic [DATA_LENGTH-1:0] F,
   output logic                   Busy,
   output logic                   Done,
   output logic                   DivZero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [DATA_LENGTH-1:0] MIN_NEG  = {1'b1, {(DATA_LENGTH-1){1'b0}}};
   localparam logic [DATA_LENGTH-1:0] ALL_ONES = {DATA_LENGTH{1'b1}};
   localparam logic [5:0]             LAST_IT  = 6'(DATA_LENGTH - 1);

   state_t                  state_q,   state_d;
   logic [5:0]              cnt_q,     cnt_d;
   logic [1:0]              op_q,      op_d;
   logic [DATA_LENGTH-1:0]  a_q,       a_d;
   logic [DATA_LENGTH-1:0]  bmag_q,    bmag_d;
   logic [DATA_LENGTH-1:0]  rem_q,     rem_d;
   logic [DATA_LENGTH-1:0]  quo_q,     quo_d;
   logic                    qneg_q,    qneg_d;
   logic                    rneg_q,    rneg_d;
   logic                    bzero_q,   bzero_d;
   logic                    ovf_q,     ovf_d;
   logic [DATA_LENGTH-1:0]  f_q,       f_d;
   logic                    busy_q,    busy_d;
   logic                    done_q,    done_d;
   logic                    divzero_q, divzero_d;

   logic                    in_signed;
   logic [DATA_LENGTH-1:0]  a_mag;
   logic [DATA_LENGTH-1:0]  b_mag;
   logic [DATA_LENGTH:0]    shift_in;
   logic [DATA_LENGTH:0]    trial;
   logic [DATA_LENGTH-1:0]  quo_res;
   logic [DATA_LENGTH-1:0]  rem_res;

   // Operand magnitudes at latch time. Signed ops are DIV/REM (Op[0]=0).
   // The magnitude of 0x80000000 is itself, which is correct as unsigned.
   always_comb begin
      in_signed = ~Op[0];
      a_mag     = (in_signed && A[DATA_LENGTH-1]) ? -A : A;
      b_mag     = (in_signed && B[DATA_LENGTH-1]) ? -B : B;
   end

   // One restoring step. The partial remainder is always below |B|, so its
   // 33rd bit is always zero and only the low 32 bits need to be stored; the
   // full 33-bit shifted value is rebuilt here for the trial subtraction.
   always_comb begin
      shift_in = {rem_q, quo_q[DATA_LENGTH-1]};
      trial    = shift_in - {1'b0, bmag_q};
   end

   // Final correction: divide-by-zero first, then signed overflow, then the
   // ordinary sign fix-up of the unsigned quotient and remainder.
   always_comb begin
      if (bzero_q) begin
         quo_res = ALL_ONES;
         rem_res = a_q;
      end else if (ovf_q) begin
         quo_res = MIN_NEG;
         rem_res = '0;
      end else begin
         quo_res = qneg_q ? -quo_q : quo_q;
         rem_res = rneg_q ? -rem_q : rem_q;
      end
   end

   // Next-state logic for the whole divider.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      bmag_d    = bmag_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      bzero_d   = bzero_q;
      ovf_d     = ovf_q;
      f_d       = f_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      divzero_d = divzero_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_CALC;
               cnt_d   = '0;
               op_d    = Op;
               a_d     = A;
               bmag_d  = b_mag;
               rem_d   = '0;
               quo_d   = a_mag;
               qneg_d  = in_signed & (A[DATA_LENGTH-1] ^ B[DATA_LENGTH-1]);
               rneg_d  = in_signed & A[DATA_LENGTH-1];
               bzero_d = (B == '0);
               ovf_d   = in_signed && (A == MIN_NEG) && (B == ALL_ONES);
               busy_d  = 1'b1;
            end
         end

         S_CALC: begin
            if (!trial[DATA_LENGTH]) begin
               rem_d = trial[DATA_LENGTH-1:0];
               quo_d = {quo_q[DATA_LENGTH-2:0], 1'b1};
            end else begin
               rem_d = shift_in[DATA_LENGTH-1:0];
               quo_d = {quo_q[DATA_LENGTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_IT) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            f_d       = op_q[1] ? rem_res : quo_res;
            divzero_d = bzero_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any operation in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         bmag_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         bzero_q   <= 1'b0;
         ovf_q     <= 1'b0;
         f_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         bmag_q    <= bmag_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         bzero_q   <= bzero_d;
         ovf_q     <= ovf_d;
         f_q       <= f_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign F       = f_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = divzero_q;

endmodule

// File: tb/tb_divider_32b.sv
// tb_divider_32b
// --------------
// Self-checking bench for divider_32b. Expected results come from a
// behavioural model using plain signed/unsigned division on wide integers.

module tb_divider_32b;

   logic        CLK;
   logic        RST;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] F;
   logic        Busy;
   logic        Done;
   logic        DivZero;

   int compared   = 0;
   int mismatched = 0;

   divider_32b #(.DATA_LENGTH(32)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .F       (F),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference: RV32M semantics from ordinary arithmetic. 64-bit signed
   // division gives +2^31 for the overflow case, which truncates correctly.
   function automatic logic [32:0] refDivide(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa;
      longint sb;
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         return {1'b1, (op[1] ? r : q)};
      end
      if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {1'b0, (op[1] ? r : q)};
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present one request before a rising edge, then scramble the operands
   // since they are don't-care after the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b);
      @(negedge CLK);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      Op    = 2'($urandom);
      A     = $urandom;
      B     = $urandom;
   endtask

   // Count edges from the accepting edge until Done, bounded.
   task automatic waitDone(output int cycles, output bit busyHeld);
      cycles   = 0;
      busyHeld = 1'b1;
      while (!Done && cycles < 40) begin
         if (!Busy) busyHeld = 1'b0;
         @(posedge CLK);
         #1;
         cycles++;
      end
   endtask

   task automatic runAndCheck(input string tag, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b);
      logic [32:0] exp;
      int          cyc;
      bit          held;
      exp = refDivide(op, a, b);
      applyStimulus(op, a, b);
      waitDone(cyc, held);
      checkOutput({tag, " latency"}, 64'(cyc), 64'd33);
      checkOutput({tag, " busy_during"}, 64'(held), 64'd1);
      checkOutput({tag, " F"}, 64'(F), 64'(exp[31:0]));
      checkOutput({tag, " DivZero"}, 64'(DivZero), 64'(exp[32]));
      checkOutput({tag, " busy_at_done"}, 64'(Busy), 64'd0);
      @(posedge CLK);
      #1;
      checkOutput({tag, " done_pulse"}, 64'(Done), 64'd0);
      checkOutput({tag, " F_hold"}, 64'(F), 64'(exp[31:0]));
   endtask

   initial begin
      logic [32:0] exp1;
      logic [32:0] exp2;
      int          doneEdge;
      int          edgeCnt;
      int          cyc2;
      bit          held;
      bit          sawDone;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      RST   = 1'b1;
      Start = 1'b0;
      Op    = 2'b00;
      A     = 32'd0;
      B     = 32'd0;
      #1;
      checkOutput("reset F", 64'(F), 64'd0);
      checkOutput("reset Busy", 64'(Busy), 64'd0);
      checkOutput("reset Done", 64'(Done), 64'd0);
      checkOutput("reset DivZero", 64'(DivZero), 64'd0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      // Directed cases from the plan.
      runAndCheck("divu_100_7", 2'b01, 32'd100, 32'd7);
      runAndCheck("remu_100_7", 2'b11, 32'd100, 32'd7);
      runAndCheck("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7);
      runAndCheck("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7);
      runAndCheck("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9);
      runAndCheck("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      runAndCheck("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      runAndCheck("divu_big_ovfpattern", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

      // Start pulses while busy must be ignored; a Start during the Done
      // cycle is accepted and completes 34 cycles after the first Done.
      exp1 = refDivide(2'b01, 32'd1000, 32'd10);
      applyStimulus(2'b01, 32'd1000, 32'd10);
      doneEdge = 0;
      edgeCnt  = 0;
      while (doneEdge == 0 && edgeCnt < 40) begin
         edgeCnt++;
         if (edgeCnt == 5 || edgeCnt == 20) begin
            Start = 1'b1;
            Op    = 2'b00;
            A     = $urandom;
            B     = 32'd3;
         end
         @(posedge CLK);
         #1;
         Start = 1'b0;
         if (Done) doneEdge = edgeCnt;
      end
      checkOutput("ignore_start done_edge", 64'(doneEdge), 64'd33);
      checkOutput("ignore_start F", 64'(F), 64'(exp1[31:0]));
      exp2  = refDivide(2'b10, 32'hFFFF_FF9C, 32'd7);
      Start = 1'b1;
      Op    = 2'b10;
      A     = 32'hFFFF_FF9C;
      B     = 32'd7;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      waitDone(cyc2, held);
      checkOutput("b2b spacing", 64'(cyc2 + 1), 64'd34);
      checkOutput("b2b busy_during", 64'(held), 64'd1);
      checkOutput("b2b F", 64'(F), 64'(exp2[31:0]));
      @(posedge CLK);
      #1;

      // Divide by zero; leaves F and DivZero non-zero before the reset test.
      runAndCheck("divu_5_0", 2'b01, 32'd5, 32'd0);
      runAndCheck("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);

      // Asynchronous reset in the middle of CALC.
      applyStimulus(2'b01, 32'd12345, 32'd7);
      repeat (10) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("midreset F", 64'(F), 64'd0);
      checkOutput("midreset Busy", 64'(Busy), 64'd0);
      checkOutput("midreset Done", 64'(Done), 64'd0);
      checkOutput("midreset DivZero", 64'(DivZero), 64'd0);
      @(negedge CLK);
      RST     = 1'b0;
      sawDone = 1'b0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (Done) sawDone = 1'b1;
      end
      checkOutput("midreset no_done", 64'(sawDone), 64'd0);
      runAndCheck("divu_max_3", 2'b01, 32'hFFFF_FFFF, 32'd3);

      // Randomized operations with corner-biased operands.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pickOperand();
         rb  = pickOperand();
         runAndCheck($sformatf("rand%0d op=%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/divider_32b.md
# divider_32b

Multi-cycle 32-bit integer divider for the RV32M datapath. It sits beside the combinational 32-bit ALU, which covers add, subtract and logic, and handles the operations the ALU cannot: DIV, DIVU, REM and REMU. It uses a radix-2 restoring algorithm with a fixed 33-cycle latency and a start/busy/done handshake toward the execute-stage control.

## Interface

Parameters:
- DATA_LENGTH, 32: operand and result width. Only 32 is supported.

Ports:
- CLK, input, 1: single clock, rising-edge.
- RST, input, 1: asynchronous, active-high reset.
- Start, input, 1: request a new division. Sampled only when Busy=0.
- Op, input, 2: operation select. 00=DIV, 01=DIVU, 10=REM, 11=REMU.
- A, input, DATA_LENGTH: dividend.
- B, input, DATA_LENGTH: divisor.
- F, output, DATA_LENGTH: result, either quotient or remainder per Op.
- Busy, output, 1: operation in progress.
- Done, output, 1: one-cycle pulse marking F valid.
- DivZero, output, 1: B was 0 for the operation just completed. Valid with Done; holds until the next Done.

## Operation

- States:
  - IDLE: waiting for Start.
  - CALC: 32 iterations.
  - FIX: sign and special-case correction.
- Transitions:
  - IDLE→CALC on Start=1. Latch Op, A and B. Clear the 6-bit iteration counter.
  - CALC→FIX when the counter reaches 31, after the 32nd iteration.
  - FIX→IDLE unconditionally.
- Signed ops (DIV, REM):
  - Operands are converted to magnitudes at latch time.
  - Record qneg = A[31]^B[31] and rneg = A[31].
- Iteration:
  - Partial remainder R is 33 bits, quotient Q is 32 bits.
  - T = {R[31:0],Q[31]} − {1'b0,|B|}.
  - If T[32]=0: R←T, Q←{Q[30:0],1}. Otherwise: R←{R[31:0],Q[31]}, Q←{Q[30:0],0}.
- FIX, in priority order:
  1. B=0: quotient result = 0xFFFFFFFF, remainder result = A (the original, signed value). DivZero=1.
  2. Signed op with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  3. Otherwise: quotient = qneg ? −Q : Q; remainder = rneg ? −R[31:0] : R[31:0].
- Op[1] selects the remainder (1) or the quotient (0) onto F.
- Special cases still take the full 33 cycles. Latency is never data-dependent.
- Start while Busy=1 is ignored. No queueing, no abort.
- F and DivZero hold their last value until the next FIX cycle.

## Timing

- Reset values: F=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0.
- RST asserted at any time, including mid-CALC:
  - Immediately forces the reset values. The in-flight operation is discarded with no Done.
  - The first Start after RST deasserts is accepted normally.
- Start accepted at rising edge k, with Busy=0 before that edge:
  - Busy=1 from after edge k.
  - CALC occupies edges k+1…k+32. FIX is edge k+33.
  - After edge k+33: Done=1 for exactly one cycle, F and DivZero updated, Busy=0.
- Back-to-back: Start may be high in the same cycle Done=1. It is accepted at edge k+34, giving one operation per 34 cycles.
- Operand inputs are don't-care except at the accepting edge.

## Test plan

- DIVU A=100, B=7, Start at edge 0 → Busy high for edges 1–33; after edge 33: Done=1 for one cycle, F=14, DivZero=0. Same operands with REMU → F=2.
- DIV A=0xFFFFFF9C (−100), B=7 → F=0xFFFFFFF2 (−14). REM with the same operands → F=0xFFFFFFFE (−2). REM A=100, B=0xFFFFFFF9 (−7) → F=2.
- DIVU A=5, B=0 → F=0xFFFFFFFF, DivZero=1. REM A=0xFFFFFFFB, B=0 → F=0xFFFFFFFB, DivZero=1. Latency is 33 cycles in both cases.
- DIV A=0x80000000, B=0xFFFFFFFF → F=0x80000000. REM with the same operands → F=0. DivZero=0 in both.
- Start pulsed at edges 5 and 20 of an in-flight DIVU 1000/10 → exactly one Done, F=100. A second Start held high during the Done cycle → accepted; its Done arrives 34 cycles after the first Done.
- RST asserted during cycle 10 of CALC → F=0, Busy=0, Done=0 immediately, and no Done follows. A subsequent DIVU 0xFFFFFFFF/3 → F=0x55555555 after 33 cycles.
